// File: rtl/video_src_gen.sv
// Raster test-pattern source: pvsync / pvde / pdata (YUV422) with programmable frame size.
// Optional scrolling ramp for pattern 1 when VSRC_MOVING_RAMP_EN is defined.
module video_src_gen #(
   parameter int VS_W    = 2,
   parameter int VBP_CYC = 4,
   parameter int HBLANK  = 3
) (
   input  logic        pclk,
   input  logic        rstn,
   input  logic        en,
   input  logic [10:0] frm_width,
   input  logic [10:0] frm_height,
   input  logic [1:0]  pat_sel,
   output logic        pvsync,
   output logic        pvde,
   output logic [15:0] pdata,
   output logic        frm_done
);

   typedef enum logic [2:0] {IDLE, VS, VBP, ACT, HBLK} state_t;

   localparam logic [15:0] VS_LAST  = 16'(VS_W - 1);
   localparam logic [15:0] VBP_LAST = 16'(VBP_CYC - 1);
   localparam logic [15:0] HB_LAST  = 16'(HBLANK - 1);

   state_t      st;
   logic [15:0] cnt;
   logic [10:0] x, y;
   logic [10:0] w, h;
   logic [1:0]  pat;
   logic [7:0]  ramp_off;

`ifdef VSRC_MOVING_RAMP_EN
   logic [7:0] frm_cnt;

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn)         frm_cnt <= 8'h00;
      else if (frm_done) frm_cnt <= frm_cnt + 8'h01;
   end

   assign ramp_off = frm_cnt;
`else
   assign ramp_off = 8'h00;
`endif

   // Chroma is a constant 8'h80, so U and V phases share one value.
   function automatic logic [15:0] pix(input logic [10:0] px, input logic [10:0] py,
                                       input logic [1:0] ps, input logic [7:0] off);
      logic [7:0] yv;
      case (ps)
         2'd0:    yv = 8'h80;
         2'd1:    yv = px[7:0] + off;
         2'd2:    yv = {px[7:5], 5'h00};
         default: yv = (px[3] ^ py[3]) ? 8'hEB : 8'h10;
      endcase
      return {yv, 8'h80};
   endfunction

   always_ff @(posedge pclk or negedge rstn) begin
      if (!rstn) begin
         st       <= IDLE;
         cnt      <= '0;
         x        <= '0;
         y        <= '0;
         w        <= '0;
         h        <= '0;
         pat      <= '0;
         pvsync   <= 1'b0;
         pvde     <= 1'b0;
         pdata    <= '0;
         frm_done <= 1'b0;
      end else begin
         frm_done <= 1'b0;
         case (st)
            IDLE: begin
               if (en) begin
                  st     <= VS;
                  cnt    <= '0;
                  pvsync <= 1'b1;
                  w      <= frm_width;
                  h      <= frm_height;
                  pat    <= pat_sel;
               end
            end
            VS: begin
               if (cnt == VS_LAST) begin
                  st     <= VBP;
                  cnt    <= '0;
                  pvsync <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            VBP: begin
               if (cnt == VBP_LAST) begin
                  st    <= ACT;
                  x     <= '0;
                  y     <= '0;
                  pvde  <= 1'b1;
                  pdata <= pix(11'd0, 11'd0, pat, ramp_off);
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ACT: begin
               if (x == w) begin
                  st       <= HBLK;
                  cnt      <= '0;
                  pvde     <= 1'b0;
                  pdata    <= '0;
                  frm_done <= (y == h);
               end else begin
                  x     <= x + 11'd1;
                  pdata <= pix(x + 11'd1, y, pat, ramp_off);
               end
            end
            HBLK: begin
               if (cnt == HB_LAST) begin
                  cnt <= '0;
                  if (y < h) begin
                     st    <= ACT;
                     x     <= '0;
                     y     <= y + 11'd1;
                     pvde  <= 1'b1;
                     pdata <= pix(11'd0, y + 11'd1, pat, ramp_off);
                  end else if (en) begin
                     // Back-to-back frame: new geometry/pattern take effect here.
                     st     <= VS;
                     pvsync <= 1'b1;
                     w      <= frm_width;
                     h      <= frm_height;
                     pat    <= pat_sel;
                  end else begin
                     st <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule
